// File: rtl/lmdpl_pkg.sv
// Shared constants and FSM state encoding for the LMDPL dual-rail decoder.
package lmdpl_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/lmdpl_dr_check.sv
// Classifies registered dual-rail pairs as spacer, complete or invalid; purely combinational.
// Zero latency, no backpressure.
module lmdpl_dr_check
  import lmdpl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rail_t,
  input  logic [WIDTH-1:0] rail_f,
  output logic             spacer,
  output logic             complete,
  output logic             invalid
);

  assign spacer   = ~|(rail_t | rail_f);
  assign complete = &(rail_t ^ rail_f);
  assign invalid  = |(rail_t & rail_f);

endmodule

// File: rtl/lmdpl_dr_decoder.sv
// Sequences precharge/evaluate of an LMDPL network and unmasks the dual-rail result.
// out_valid two edges after completion hits the rails; result is held in OUT until out_ready.
module lmdpl_dr_decoder
  import lmdpl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] dr_t,
  input  logic [WIDTH-1:0] dr_f,
  output logic             pre,
  output logic             eval,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_invalid,
  output logic             err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] mask_q, mask_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             vld_q, vld_nxt;
  logic             einv_q, einv_nxt;
  logic             etmo_q, etmo_nxt;
  logic [WIDTH-1:0] dr_t_q, dr_f_q;
  logic             spacer, complete, invalid;

  lmdpl_dr_check #(.WIDTH(WIDTH)) u_check (
    .rail_t   (dr_t_q),
    .rail_f   (dr_f_q),
    .spacer   (spacer),
    .complete (complete),
    .invalid  (invalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mask_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      einv_q <= 1'b0;
      etmo_q <= 1'b0;
      dr_t_q <= '0;
      dr_f_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mask_q <= mask_nxt;
      data_q <= data_nxt;
      vld_q  <= vld_nxt;
      einv_q <= einv_nxt;
      etmo_q <= etmo_nxt;
      dr_t_q <= dr_t;
      dr_f_q <= dr_f;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = mask_q;
    data_nxt  = data_q;
    vld_nxt   = vld_q;
    einv_nxt  = einv_q;
    etmo_nxt  = etmo_q;
    case (state)
      IDLE: begin
        // A new evaluation may only begin from a fully precharged network.
        if (start && spacer) begin
          mask_nxt  = mask;
          einv_nxt  = 1'b0;
          etmo_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (invalid) begin
          einv_nxt  = 1'b1;
          state_nxt = DRAIN;
        end else if (complete) begin
          data_nxt  = dr_t_q ^ mask_q;
          vld_nxt   = 1'b1;
          state_nxt = OUT;
        end else if (cnt == CNT_LAST) begin
          etmo_nxt  = 1'b1;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (spacer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pre         = (state != EVAL);
  assign eval        = ~pre;
  assign busy        = (state != IDLE);
  assign out_valid   = vld_q;
  assign out_data    = data_q;
  assign err_invalid = einv_q;
  assign err_timeout = etmo_q;

endmodule

// File: tb/tb_lmdpl_dr_decoder.sv
// Directed bench for lmdpl_dr_decoder with a cycle model checked on every falling edge.
module tb_lmdpl_dr_decoder;

  localparam int W  = 8;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [W-1:0] mask, dr_t, dr_f, out_data;
  logic         pre, eval, busy, out_valid, err_invalid, err_timeout;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  lmdpl_dr_decoder #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mask        (mask),
    .dr_t        (dr_t),
    .dr_f        (dr_f),
    .pre         (pre),
    .eval        (eval),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout)
  );

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 evaluating, 2 result offered, 3 waiting for spacer.
  int           m_phase, m_cnt;
  logic [W-1:0] m_rt, m_rf, m_mask, m_od;
  bit           m_ov, m_ei, m_et;

  task automatic model_step();
    int nz, n1, nb;
    nz = 0; n1 = 0; nb = 0;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_rt = '0; m_rf = '0;
      m_mask = '0; m_od = '0; m_ov = 0; m_ei = 0; m_et = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (m_rt[i] && m_rf[i]) nb++;
        else if (m_rt[i] != m_rf[i]) n1++;
        else nz++;
      end
      case (m_phase)
        0: if (start && nz == W) begin
             m_mask = mask; m_ei = 0; m_et = 0; m_cnt = 0; m_phase = 1;
           end
        1: if (nb > 0) begin
             m_ei = 1; m_phase = 3;
           end else if (n1 == W) begin
             m_od = m_rt ^ m_mask; m_ov = 1; m_phase = 2;
           end else if (m_cnt + 1 == TO) begin
             m_et = 1; m_phase = 3;
           end else begin
             m_cnt++;
           end
        2: if (out_ready) begin
             m_ov = 0; m_phase = 3;
           end
        default: if (nz == W) m_phase = 0;
      endcase
      m_rt = dr_t;
      m_rf = dr_f;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      chkb("m_pre", pre, m_phase != 1);
      chkb("m_eval", eval, m_phase == 1);
      chkb("m_busy", busy, m_phase != 0);
      chkb("m_out_valid", out_valid, m_ov);
      chkv("m_out_data", 32'(out_data), 32'(m_od));
      chkb("m_err_invalid", err_invalid, m_ei);
      chkb("m_err_timeout", err_timeout, m_et);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 6) begin
      tick();
      n++;
    end
    chkb(name, out_valid, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mask = '0; dr_t = '0; dr_f = '0; out_ready = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    chkb("rst_pre", pre, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ov", out_valid, 1'b0);
    chkv("rst_od", 32'(out_data), 32'h0);
    rst = 1'b0;

    // Basic unmask with two-edge latency
    mask = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    chkb("a_busy", busy, 1'b1);
    chkb("a_eval", eval, 1'b1);
    dr_t = 8'hA5; dr_f = 8'h5A;
    tick();
    chkb("a_lat1_ov", out_valid, 1'b0);
    tick();
    chkb("a_lat2_ov", out_valid, 1'b1);
    chkv("a_data", 32'(out_data), 32'h99);
    chkb("a_pre_out", pre, 1'b1);
    dr_t = '0; dr_f = '0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkb("a_hs_ov", out_valid, 1'b0);
    chkb("a_drain_busy", busy, 1'b1);
    tick();
    chkb("a_idle_busy", busy, 1'b0);

    // Backpressure: result held while out_ready low, start ignored meanwhile
    mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    dr_t = 8'h0F; dr_f = 8'hF0;
    wait_ov("b_wait_ov");
    start = 1'b1; dr_t = '0; dr_f = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chkb("b_hold_ov", out_valid, 1'b1);
      chkv("b_hold_data", 32'(out_data), 32'hF0);
    end
    start = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkb("b_hs_ov", out_valid, 1'b0);
    chkb("b_drain_busy", busy, 1'b1);
    tick();
    chkb("b_idle_busy", busy, 1'b0);

    // Invalid pair detection and drain
    mask = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    dr_t = 8'h08; dr_f = 8'hFF;
    tick();
    tick();
    chkb("c_err_inv", err_invalid, 1'b1);
    chkb("c_ov", out_valid, 1'b0);
    chkb("c_pre", pre, 1'b1);
    repeat (3) tick();
    chkb("c_drain_hold", busy, 1'b1);
    dr_t = '0; dr_f = '0;
    tick();
    chkb("c_drain_lag", busy, 1'b1);
    tick();
    chkb("c_idle", busy, 1'b0);
    chkb("c_sticky", err_invalid, 1'b1);

    // Timeout after exactly TO evaluation cycles
    mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chkb("d_clear_inv", err_invalid, 1'b0);
    n = 0;
    while (!err_timeout && n < 40) begin
      tick();
      n++;
    end
    chkv("d_cycles", 32'(n), 32'd15);
    chkb("d_drain_busy", busy, 1'b1);
    chkb("d_ov", out_valid, 1'b0);
    tick();
    chkb("d_idle", busy, 1'b0);
    chkb("d_sticky", err_timeout, 1'b1);

    // start without spacer is ignored
    dr_t = 8'h01;
    tick();
    start = 1'b1;
    tick();
    chkb("e_nostart", busy, 1'b0);
    tick();
    chkb("e_nostart2", busy, 1'b0);
    start = 1'b0; dr_t = '0;
    tick();

    // Reset mid-EVAL
    mask = 8'hC3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chkb("f_in_eval", eval, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("f_busy", busy, 1'b0);
    chkb("f_pre", pre, 1'b1);
    chkb("f_err_inv", err_invalid, 1'b0);
    chkb("f_err_tmo", err_timeout, 1'b0);

    // Reset mid-OUT
    mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    dr_t = 8'hAA; dr_f = 8'h55;
    wait_ov("g_wait_ov");
    chkv("g_data", 32'(out_data), 32'hAA);
    rst = 1'b1; dr_t = '0; dr_f = '0;
    tick();
    rst = 1'b0;
    chkb("g_ov", out_valid, 1'b0);
    chkv("g_od", 32'(out_data), 32'h0);
    chkb("g_busy", busy, 1'b0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lmdpl_dr_decoder.md
LMDPL_DR_DECODER -- requirements
Module: lmdpl_dr_decoder

Interface
REQ-001 Parameter WIDTH, default 8: number of masked dual-rail bit pairs decoded per evaluation.
REQ-002 Parameter TIMEOUT, default 15: maximum EVAL cycles allowed before completion is declared failed.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request to begin one evaluation; sampled only in IDLE.
REQ-006 mask  input  WIDTH  mask word for this evaluation; latched when start is accepted.
REQ-007 dr_t  input  WIDTH  true rails from the LMDPL gate network.
REQ-008 dr_f  input  WIDTH  false rails from the LMDPL gate network.
REQ-009 pre  output  1  precharge command to the gate network; high means precharge.
REQ-010 eval  output  1  evaluate command; always equals NOT pre.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 out_valid  output  1  unmasked result available.
REQ-013 out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-014 out_data  output  WIDTH  unmasked single-rail result.
REQ-015 err_invalid  output  1  sticky flag: a pair had both rails high during EVAL.
REQ-016 err_timeout  output  1  sticky flag: EVAL ended without completion.

Function
REQ-017 dr_t and dr_f SHALL be registered every cycle into dr_t_q and dr_f_q; all decisions SHALL use only these registered copies.
REQ-018 Pair status SHALL be decoded from the registered rails:
- spacer: all pairs 00.
- complete: every pair exactly one-hot.
- invalid: any pair 11.
REQ-019 The FSM SHALL have four states: IDLE, EVAL, OUT, DRAIN.
REQ-020 IDLE: pre=1, busy=0. On start=1 with spacer, the block SHALL latch mask into mask_q, clear both error flags, clear cnt and go to EVAL. On start=1 without spacer, start SHALL be ignored.
REQ-021 EVAL: pre=0. Each cycle, checks apply in this priority order:
- invalid: set err_invalid, go to DRAIN.
- else complete: register out_data = dr_t_q XOR mask_q, set out_valid=1, go to OUT.
- else cnt==TIMEOUT-1: set err_timeout, go to DRAIN.
- else: increment cnt.
REQ-022 OUT: pre=1. out_valid and out_data SHALL stay stable until out_valid&&out_ready. On that cycle out_valid SHALL clear and the FSM SHALL go to DRAIN.
REQ-023 DRAIN: pre=1. The FSM SHALL stay until spacer is observed, then go to IDLE.
REQ-024 Latency: completion present on dr_t/dr_f at edge k gives out_valid=1 after edge k+2.
REQ-025 start in any state other than IDLE SHALL be ignored.
REQ-026 out_valid SHALL never assert in an evaluation that set either error flag.
REQ-027 Error flags SHALL hold until the next accepted start or reset.
REQ-028 cnt SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL never wrap.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set: state=IDLE, pre=1, busy=0, out_valid=0, out_data=0, err_invalid=0, err_timeout=0, cnt=0, mask_q=0, dr_t_q=0, dr_f_q=0.
REQ-030 Reset SHALL take priority over every other event, including mid-EVAL and mid-OUT.

Structure
REQ-031 Package lmdpl_pkg SHALL hold the state enum and the WIDTH and TIMEOUT default constants.
REQ-032 A combinational sub-module lmdpl_dr_check SHALL compute spacer, complete and invalid from the registered rail pairs.
REQ-033 All state SHALL be held in flops inside lmdpl_dr_decoder.

Verification
REQ-034 WIDTH=8, start with rails 00, mask=0x3C; then dr_t=0xA5, dr_f=0x5A -> out_data=0x99, out_valid two edges later, pre=1 in OUT.
REQ-035 In EVAL, dr_t=0x08 and dr_f=0xFF -> err_invalid=1, out_valid stays 0, DRAIN holds until rails return to 00, then IDLE.
REQ-036 TIMEOUT=15, rails held 00 after start -> err_timeout=1 after exactly 15 EVAL cycles, then DRAIN and IDLE.
REQ-037 out_ready held low 5 cycles after out_valid -> out_data and out_valid stable; handshake on cycle 6 -> DRAIN.
REQ-038 start in IDLE with dr_t=0x01 (no spacer) -> no transition; rst pulse mid-EVAL -> IDLE, pre=1, flags 0 on the next cycle.
